// File: rtl/mem_pkg.sv
// Shared defaults and FSM state encoding for the memory request master.
package mem_pkg;

    localparam int DATA_SIZE_DEF  = 2;
    localparam int ADDR_W_DEF     = 14;
    localparam int FIFO_DEPTH_DEF = 4;
    localparam int TIMEOUT_DEF    = 64;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } mem_master_state_t;

endpackage

// File: rtl/mem_req_fifo.sv
// Synchronous request FIFO: read/write pointers plus an occupancy count.
module mem_req_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign full     = (count_q == (PTR_W+1)'(DEPTH));
    assign empty    = (count_q == '0);
    assign pop_data = mem_q[rd_ptr_q];

    always_comb begin
        do_push  = push & ~full;
        do_pop   = pop & ~empty;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        mem_d    = mem_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: the pointers alone define what is valid.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/mem_req_master.sv
// Queues core requests and issues them one at a time to shared memory,
// aborting with an error response if memory does not answer in time.
module mem_req_master
    import mem_pkg::*;
#(
    parameter int DATA_SIZE  = DATA_SIZE_DEF,
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
    parameter int TIMEOUT    = TIMEOUT_DEF
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   core_req_valid,
    output logic                   core_req_ready,
    input  logic                   core_req_we,
    input  logic [ADDR_W-1:0]      core_req_addr,
    input  logic [DATA_SIZE*8-1:0] core_req_wdata,
    output logic                   core_rsp_valid,
    input  logic                   core_rsp_ready,
    output logic [DATA_SIZE*8-1:0] core_rsp_rdata,
    output logic                   core_rsp_err,
    output logic                   processor_req,
    output logic                   mem_read_req,
    output logic                   mem_write_req,
    output logic [ADDR_W-1:0]      addr,
    output logic [DATA_SIZE*8-1:0] mem_write_data,
    input  logic [DATA_SIZE*8-1:0] mem_read_data,
    input  logic                   processor_resp,
    output logic                   busy
);

    localparam int DW      = DATA_SIZE * 8;
    localparam int ENTRY_W = 1 + ADDR_W + DW;
    localparam int CNT_W   = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    mem_master_state_t state_q, state_d;

    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               rst_done_q, rst_done_d;
    logic               processor_req_q, processor_req_d;
    logic               mem_read_req_q, mem_read_req_d;
    logic               mem_write_req_q, mem_write_req_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [DW-1:0]      wdata_q, wdata_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic [DW-1:0]      rsp_rdata_q, rsp_rdata_d;
    logic               rsp_err_q, rsp_err_d;

    logic               fifo_push;
    logic               fifo_pop;
    logic               fifo_full;
    logic               fifo_empty;
    logic [ENTRY_W-1:0] fifo_wdata;
    logic [ENTRY_W-1:0] fifo_rdata;
    logic               head_we;
    logic [ADDR_W-1:0]  head_addr;
    logic [DW-1:0]      head_wdata;
    logic               load_cmd;
    logic               clear_cmd;

    // Ready is gated by a flop that is low throughout reset and rises
    // on the first edge after it; there is deliberately no pop bypass.
    assign core_req_ready = rst_done_q & ~fifo_full;
    assign fifo_push      = core_req_valid & core_req_ready;
    assign fifo_wdata     = {core_req_we, core_req_addr, core_req_wdata};
    assign head_we        = fifo_rdata[ENTRY_W-1];
    assign head_addr      = fifo_rdata[DW +: ADDR_W];
    assign head_wdata     = fifo_rdata[DW-1:0];

    mem_req_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (fifo_push),
        .push_data (fifo_wdata),
        .pop       (fifo_pop),
        .pop_data  (fifo_rdata),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_comb begin
        state_d         = state_q;
        cnt_d           = cnt_q;
        rst_done_d      = 1'b1;
        processor_req_d = processor_req_q;
        mem_read_req_d  = mem_read_req_q;
        mem_write_req_d = mem_write_req_q;
        addr_d          = addr_q;
        wdata_d         = wdata_q;
        rsp_valid_d     = rsp_valid_q;
        rsp_rdata_d     = rsp_rdata_q;
        rsp_err_d       = rsp_err_q;
        fifo_pop        = 1'b0;
        load_cmd        = 1'b0;
        clear_cmd       = 1'b0;

        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    load_cmd = 1'b1;
                    state_d  = ISSUE;
                end
            end
            ISSUE: begin
                // A response on the final timeout cycle still counts as success.
                if (processor_resp) begin
                    state_d     = RESP;
                    clear_cmd   = 1'b1;
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = mem_write_req_q ? '0 : mem_read_data;
                    rsp_err_d   = 1'b0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d     = RESP;
                    clear_cmd   = 1'b1;
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = '0;
                    rsp_err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RESP: begin
                if (core_rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    rsp_rdata_d = '0;
                    rsp_err_d   = 1'b0;
                    if (!fifo_empty) begin
                        load_cmd = 1'b1;
                        state_d  = ISSUE;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (clear_cmd) begin
            processor_req_d = 1'b0;
            mem_read_req_d  = 1'b0;
            mem_write_req_d = 1'b0;
            addr_d          = '0;
            wdata_d         = '0;
        end

        // The memory-side flops double as the command register.
        if (load_cmd) begin
            fifo_pop        = 1'b1;
            processor_req_d = 1'b1;
            mem_read_req_d  = ~head_we;
            mem_write_req_d = head_we;
            addr_d          = head_addr;
            wdata_d         = head_wdata;
            cnt_d           = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q         <= IDLE;
            cnt_q           <= '0;
            rst_done_q      <= 1'b0;
            processor_req_q <= 1'b0;
            mem_read_req_q  <= 1'b0;
            mem_write_req_q <= 1'b0;
            addr_q          <= '0;
            wdata_q         <= '0;
            rsp_valid_q     <= 1'b0;
            rsp_rdata_q     <= '0;
            rsp_err_q       <= 1'b0;
        end else begin
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            rst_done_q      <= rst_done_d;
            processor_req_q <= processor_req_d;
            mem_read_req_q  <= mem_read_req_d;
            mem_write_req_q <= mem_write_req_d;
            addr_q          <= addr_d;
            wdata_q         <= wdata_d;
            rsp_valid_q     <= rsp_valid_d;
            rsp_rdata_q     <= rsp_rdata_d;
            rsp_err_q       <= rsp_err_d;
        end
    end

    assign processor_req  = processor_req_q;
    assign mem_read_req   = mem_read_req_q;
    assign mem_write_req  = mem_write_req_q;
    assign addr           = addr_q;
    assign mem_write_data = wdata_q;
    assign core_rsp_valid = rsp_valid_q;
    assign core_rsp_rdata = rsp_rdata_q;
    assign core_rsp_err   = rsp_err_q;
    assign busy           = ~fifo_empty | (state_q != IDLE);

endmodule

// File: tb/tb_mem_req_master.sv
// Directed scoreboard bench for mem_req_master (TIMEOUT overridden to 8).
module tb_mem_req_master;

    localparam int DW = 16;
    localparam int AW = 14;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          core_req_valid;
    logic          core_req_ready;
    logic          core_req_we;
    logic [AW-1:0] core_req_addr;
    logic [DW-1:0] core_req_wdata;
    logic          core_rsp_valid;
    logic          core_rsp_ready;
    logic [DW-1:0] core_rsp_rdata;
    logic          core_rsp_err;
    logic          processor_req;
    logic          mem_read_req;
    logic          mem_write_req;
    logic [AW-1:0] addr;
    logic [DW-1:0] mem_write_data;
    logic [DW-1:0] mem_read_data;
    logic          processor_resp;
    logic          busy;

    typedef struct packed {
        logic [DW-1:0] rdata;
        logic          err;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    mem_req_master #(
        .DATA_SIZE  (2),
        .ADDR_W     (AW),
        .FIFO_DEPTH (4),
        .TIMEOUT    (8)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .core_req_valid (core_req_valid),
        .core_req_ready (core_req_ready),
        .core_req_we    (core_req_we),
        .core_req_addr  (core_req_addr),
        .core_req_wdata (core_req_wdata),
        .core_rsp_valid (core_rsp_valid),
        .core_rsp_ready (core_rsp_ready),
        .core_rsp_rdata (core_rsp_rdata),
        .core_rsp_err   (core_rsp_err),
        .processor_req  (processor_req),
        .mem_read_req   (mem_read_req),
        .mem_write_req  (mem_write_req),
        .addr           (addr),
        .mem_write_data (mem_write_data),
        .mem_read_data  (mem_read_data),
        .processor_resp (processor_resp),
        .busy           (busy)
    );

    // Memory model contents: data is a fixed function of the address.
    function automatic logic [DW-1:0] mem_data(input logic [AW-1:0] a);
        return {2'b10, a} ^ 16'h5A5A;
    endfunction

    function automatic exp_t mk(input logic [DW-1:0] d, input logic e);
        exp_t x;
        x.rdata = d;
        x.err   = e;
        return x;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push_req(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        int w = 0;
        while (!core_req_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        if (!core_req_ready) begin
            check("push_wait", 32'(core_req_ready), 32'd1);
            return;
        end
        core_req_valid = 1'b1;
        core_req_we    = we;
        core_req_addr  = a;
        core_req_wdata = d;
        @(negedge clk);
        core_req_valid = 1'b0;
    endtask

    task automatic serve(input int delay, input string tag);
        int w = 0;
        while (!processor_req && w < 50) begin
            @(negedge clk);
            w++;
        end
        if (!processor_req) begin
            check({tag, "_req_wait"}, 32'(processor_req), 32'd1);
            return;
        end
        repeat (delay) @(negedge clk);
        processor_resp = 1'b1;
        mem_read_data  = mem_data(addr);
        @(negedge clk);
        processor_resp = 1'b0;
        mem_read_data  = 16'($urandom);
    endtask

    task automatic get_rsp(input string tag);
        int   w = 0;
        exp_t e;
        while (!core_rsp_valid && w < 100) begin
            @(negedge clk);
            w++;
        end
        if (!core_rsp_valid) begin
            check({tag, "_rsp_wait"}, 32'(core_rsp_valid), 32'd1);
            return;
        end
        if (sb.size() == 0) begin
            check({tag, "_unexpected_rsp"}, 32'(sb.size()), 32'd1);
        end else begin
            e = sb.pop_front();
            check({tag, "_rdata"}, 32'(core_rsp_rdata), 32'(e.rdata));
            check({tag, "_err"}, 32'(core_rsp_err), 32'(e.err));
        end
        core_rsp_ready = 1'b1;
        @(negedge clk);
        core_rsp_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int seen_valid;
        int seen_req;
        int seen_busy;
        logic [AW-1:0] a;

        reset_n        = 1'b0;
        core_req_valid = 1'b0;
        core_req_we    = 1'b0;
        core_req_addr  = '0;
        core_req_wdata = '0;
        core_rsp_ready = 1'b0;
        mem_read_data  = '0;
        processor_resp = 1'b0;

        repeat (2) @(negedge clk);
        check("rst_ready", 32'(core_req_ready), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_preq", 32'(processor_req), 32'd0);
        check("rst_rsp_valid", 32'(core_rsp_valid), 32'd0);
        reset_n = 1'b1;
        @(negedge clk);
        check("post_rst_ready", 32'(core_req_ready), 32'd1);
        check("post_rst_busy", 32'(busy), 32'd0);

        // Read of 0x0005, memory answers three cycles into ISSUE
        sb.push_back(mk(16'h0006, 1'b0));
        push_req(1'b0, 14'h0005, 16'h0000);
        check("rd_latency_preq", 32'(processor_req), 32'd0);
        check("rd_busy", 32'(busy), 32'd1);
        @(negedge clk);
        check("rd_preq", 32'(processor_req), 32'd1);
        check("rd_rdreq", 32'(mem_read_req), 32'd1);
        check("rd_wrreq", 32'(mem_write_req), 32'd0);
        check("rd_addr", 32'(addr), 32'h0005);
        repeat (2) @(negedge clk);
        processor_resp = 1'b1;
        mem_read_data  = 16'h0006;
        @(negedge clk);
        processor_resp = 1'b0;
        mem_read_data  = 16'hDEAD;
        check("rd_rsp_valid", 32'(core_rsp_valid), 32'd1);
        check("rd_rsp_rdata", 32'(core_rsp_rdata), 32'h0006);
        check("rd_rsp_err", 32'(core_rsp_err), 32'd0);
        check("rd_preq_low", 32'(processor_req), 32'd0);
        check("rd_rdreq_low", 32'(mem_read_req), 32'd0);
        check("rd_addr_low", 32'(addr), 32'd0);
        processor_resp = 1'b1;
        mem_read_data  = 16'hFFFF;
        @(negedge clk);
        processor_resp = 1'b0;
        check("stray_resp_hold_valid", 32'(core_rsp_valid), 32'd1);
        check("stray_resp_hold_rdata", 32'(core_rsp_rdata), 32'h0006);
        get_rsp("rd5");
        check("rd_idle_busy", 32'(busy), 32'd0);
        check("rd_idle_valid", 32'(core_rsp_valid), 32'd0);

        // Write to the top word address; bus must stay stable until resp
        sb.push_back(mk(16'h0000, 1'b0));
        push_req(1'b1, 14'h3FFF, 16'hBEEF);
        @(negedge clk);
        for (int c = 0; c < 3; c++) begin
            check("wr_wrreq", 32'(mem_write_req), 32'd1);
            check("wr_rdreq", 32'(mem_read_req), 32'd0);
            check("wr_addr", 32'(addr), 32'h3FFF);
            check("wr_wdata", 32'(mem_write_data), 32'hBEEF);
            @(negedge clk);
        end
        processor_resp = 1'b1;
        mem_read_data  = 16'h1234;
        @(negedge clk);
        processor_resp = 1'b0;
        check("wr_preq_low", 32'(processor_req), 32'd0);
        check("wr_wrreq_low", 32'(mem_write_req), 32'd0);
        check("wr_wdata_low", 32'(mem_write_data), 32'd0);
        get_rsp("wr");

        // Five back-to-back reads: four queued plus one in flight
        for (int i = 0; i < 5; i++) begin
            a = 14'h0100 + AW'(i);
            sb.push_back(mk(mem_data(a), 1'b0));
            check("b2b_ready", 32'(core_req_ready), 32'd1);
            core_req_valid = 1'b1;
            core_req_we    = 1'b0;
            core_req_addr  = a;
            core_req_wdata = '0;
            @(negedge clk);
        end
        core_req_valid = 1'b0;
        check("b2b_full_ready", 32'(core_req_ready), 32'd0);
        check("b2b_busy", 32'(busy), 32'd1);
        serve(0, "b2b0");
        check("b2b_full_in_resp", 32'(core_req_ready), 32'd0);
        core_rsp_ready = 1'b1;
        #1;
        check("b2b_no_bypass", 32'(core_req_ready), 32'd0);
        get_rsp("b2b0");
        check("b2b_ready_after_pop", 32'(core_req_ready), 32'd1);
        for (int i = 1; i < 5; i++) begin
            serve(i % 3, "b2b");
            get_rsp("b2b");
        end

        // No memory answer: abort after exactly 8 ISSUE cycles
        sb.push_back(mk(16'h0000, 1'b1));
        push_req(1'b0, 14'h0022, 16'h0000);
        @(negedge clk);
        n = 0;
        while (processor_req && n < 20) begin
            n++;
            @(negedge clk);
        end
        check("timeout_cycles", 32'(n), 32'd8);
        get_rsp("timeout");

        sb.push_back(mk(mem_data(14'h0023), 1'b0));
        push_req(1'b0, 14'h0023, 16'h0000);
        serve(1, "after_timeout");
        get_rsp("after_timeout");

        // Response on the same edge as the timeout wins
        sb.push_back(mk(mem_data(14'h0024), 1'b0));
        push_req(1'b0, 14'h0024, 16'h0000);
        serve(7, "race");
        get_rsp("race");

        // Stray processor_resp while idle
        check("stray_pre_busy", 32'(busy), 32'd0);
        processor_resp = 1'b1;
        mem_read_data  = 16'h7777;
        @(negedge clk);
        processor_resp = 1'b0;
        check("stray_idle_valid", 32'(core_rsp_valid), 32'd0);
        check("stray_idle_busy", 32'(busy), 32'd0);
        check("stray_idle_preq", 32'(processor_req), 32'd0);
        repeat (3) @(negedge clk);
        check("stray_idle_valid_late", 32'(core_rsp_valid), 32'd0);

        // Reset with one transaction in ISSUE and two queued
        for (int i = 0; i < 3; i++) begin
            core_req_valid = 1'b1;
            core_req_we    = (i == 0);
            core_req_addr  = 14'h0200 + AW'(i);
            core_req_wdata = 16'hA5A5;
            @(negedge clk);
        end
        core_req_valid = 1'b0;
        check("mid_rst_pre_preq", 32'(processor_req), 32'd1);
        check("mid_rst_pre_wdata", 32'(mem_write_data), 32'hA5A5);
        reset_n = 1'b0;
        @(negedge clk);
        check("mid_rst_preq", 32'(processor_req), 32'd0);
        check("mid_rst_rdreq", 32'(mem_read_req), 32'd0);
        check("mid_rst_wrreq", 32'(mem_write_req), 32'd0);
        check("mid_rst_addr", 32'(addr), 32'd0);
        check("mid_rst_wdata", 32'(mem_write_data), 32'd0);
        check("mid_rst_valid", 32'(core_rsp_valid), 32'd0);
        check("mid_rst_rdata", 32'(core_rsp_rdata), 32'd0);
        check("mid_rst_err", 32'(core_rsp_err), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_ready", 32'(core_req_ready), 32'd0);
        reset_n        = 1'b1;
        core_rsp_ready = 1'b1;
        seen_valid = 0;
        seen_req   = 0;
        seen_busy  = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (core_rsp_valid) seen_valid++;
            if (processor_req) seen_req++;
            if (busy) seen_busy++;
        end
        core_rsp_ready = 1'b0;
        check("post_mid_rst_rsp_count", 32'(seen_valid), 32'd0);
        check("post_mid_rst_req_count", 32'(seen_req), 32'd0);
        check("post_mid_rst_busy_count", 32'(seen_busy), 32'd0);
        check("post_mid_rst_ready", 32'(core_req_ready), 32'd1);

        check("scoreboard_drained", 32'(sb.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_req_master.md
MEM_REQ_MASTER -- requirements
Module: mem_req_master

Interface
REQ-001 Parameter DATA_SIZE, default 2, data width in bytes (data bus = DATA_SIZE*8 bits).
REQ-002 Parameter ADDR_W, default 14, word address width.
REQ-003 Parameter FIFO_DEPTH, default 4, pending core requests (power of two, >=2).
REQ-004 Parameter TIMEOUT, default 64, cycles in ISSUE before error abort (>=2).
REQ-005 clk  input  1  clock; all logic on rising edge.
REQ-006 reset_n  input  1  reset, synchronous, active-low.
REQ-007 core_req_valid  input  1  core request present.
REQ-008 core_req_ready  output  1  request accepted when valid&ready at rising edge.
REQ-009 core_req_we  input  1  1=write, 0=read.
REQ-010 core_req_addr  input  ADDR_W  word address.
REQ-011 core_req_wdata  input  DATA_SIZE*8  write data.
REQ-012 core_rsp_valid  output  1  response present.
REQ-013 core_rsp_ready  input  1  response consumed when valid&ready at rising edge.
REQ-014 core_rsp_rdata  output  DATA_SIZE*8  read data; 0 for writes and errors.
REQ-015 core_rsp_err  output  1  1=transaction timed out.
REQ-016 processor_req  output  1  memory request strobe toward shared memory.
REQ-017 mem_read_req / mem_write_req  output  1 each  operation qualifiers, mutually exclusive.
REQ-018 addr  output  ADDR_W  memory address.
REQ-019 mem_write_data  output  DATA_SIZE*8  memory write data.
REQ-020 mem_read_data  input  DATA_SIZE*8  memory read data, valid while processor_resp high.
REQ-021 processor_resp  input  1  grant/completion from memory (may change on falling edge; sampled on rising edge only).
REQ-022 busy  output  1  high when FIFO non-empty or FSM not IDLE.

Function
REQ-023 Request FIFO: core_req_ready = !full; push on valid&ready; no bypass, so a full FIFO SHALL deassert ready even in a cycle the FSM pops.
REQ-024 FSM states IDLE, ISSUE, RESP; IDLE with FIFO non-empty pops head into command register and enters ISSUE at same edge.
REQ-025 In ISSUE, processor_req=1, mem_read_req=!we, mem_write_req=we, addr/mem_write_data from command register, all registered and stable for whole ISSUE.
REQ-026 Latency: request pushed at edge N drives processor_req high after edge N+1 (empty FIFO, FSM IDLE).
REQ-027 processor_resp sampled high at edge K in ISSUE: capture mem_read_data (reads) or 0 (writes), err=0, enter RESP; all memory outputs low after edge K.
REQ-028 Timeout counter cleared on ISSUE entry, increments each ISSUE cycle without resp; reaching TIMEOUT-1 without resp aborts: memory outputs low, rdata=0, err=1, enter RESP.
REQ-029 processor_resp and timeout at same edge: resp wins, err=0.
REQ-030 RESP holds core_rsp_valid/rdata/err stable until core_rsp_ready; then IDLE, or directly ISSUE if FIFO non-empty (pop same edge).
REQ-031 processor_resp outside ISSUE SHALL be ignored.
REQ-032 Requests complete strictly in FIFO order; one outstanding memory transaction max.

Reset
REQ-033 reset_n low at rising edge: FSM IDLE, FIFO flushed, counter 0, all outputs 0 except core_req_ready=0 during reset, 1 first cycle after.
REQ-034 Reset mid-ISSUE or mid-RESP drops transaction silently; no response produced.

Structure
REQ-035 Package mem_pkg holds DATA_SIZE/ADDR_W defaults and state enum mem_master_state_t {IDLE, ISSUE, RESP}.
REQ-036 FIFO is sub-module mem_req_fifo (sync, pointer+count, full/empty flags).

Verification
REQ-037 Read addr 0x0005, resp high 3 cycles after issue with data 0x0006 -> rsp_valid, rdata=0x0006, err=0, outputs low next cycle.
REQ-038 Write addr 0x3FFF data 0xBEEF -> mem_write_req=1, addr=0x3FFF, data 0xBEEF stable until resp; rsp rdata=0, err=0.
REQ-039 Push 5 requests back-to-back, rsp_ready=0 -> ready low after 4th accepted (plus one in command register); all 5 return in order.
REQ-040 TIMEOUT=8, resp never asserted -> abort after 8 ISSUE cycles, err=1, rdata=0; next request then issues normally.
REQ-041 Reset asserted while ISSUE and 2 queued -> all outputs 0 next edge, no rsp_valid ever, busy=0.
REQ-042 Stray processor_resp pulse in IDLE -> no response, no state change.
